// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier control unit.
// Holds the state encoding, the {q0,q_lsb} decode constants and the output decode table.
package booth_pkg;

  localparam int BOOTH_N = 8;

  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LD_M,
    S_LD_Q,
    S_DEC,
    S_ADD,
    S_SUB,
    S_SHF,
    S_OUT_A,
    S_OUT_Q,
    S_DONE
  } state_e;

  // c[k] is datapath strobe ck; c[5] is reserved and never set here.
  typedef struct packed {
    logic [7:0] c;
    logic       ready;
    logic       done;
  } ctrl_t;

  function automatic ctrl_t ctrl_decode(input state_e s);
    ctrl_t o;
    o = '0;
    case (s)
      S_IDLE:  o.ready = 1'b1;
      S_LD_M:  o.c[0]  = 1'b1;
      S_LD_Q:  o.c[1]  = 1'b1;
      S_ADD:   o.c[2]  = 1'b1;
      S_SUB:   o.c[3]  = 1'b1;
      S_SHF:   o.c[4]  = 1'b1;
      S_OUT_A: o.c[6]  = 1'b1;
      S_OUT_Q: o.c[7]  = 1'b1;
      S_DONE:  o.done  = 1'b1;
      default: o       = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/booth_cnt.sv
// Booth iteration counter: cleared at operand load, advanced once per shift.
// Saturates at N-1 so it never wraps within an operation.
module booth_cnt import booth_pkg::*; #(
  parameter int N  = BOOTH_N,
  parameter int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          last
);

  assign last = (cnt == CW'(N - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !last) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/booth_ctrl.sv
// Moore control FSM for the radix-2 Booth datapath: load, add/sub, shift, readout.
// All outputs are registered and reflect the current state only.
module booth_ctrl import booth_pkg::*; #(
  parameter  int N  = BOOTH_N,
  localparam int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          q0,
  input  logic          q_lsb,
  output logic          c0,
  output logic          c1,
  output logic          c2,
  output logic          c3,
  output logic          c4,
  output logic          c5,
  output logic          c6,
  output logic          c7,
  output logic          ready,
  output logic          done,
  output logic [CW-1:0] cnt
);

  state_e  state;
  state_e  state_nxt;
  ctrl_t   ctrl_q;
  logic    cnt_clr;
  logic    cnt_inc;
  logic    cnt_last;

  assign cnt_clr = (state == S_LD_M);
  assign cnt_inc = (state == S_SHF);

  booth_cnt #(.N(N), .CW(CW)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .cnt  (cnt),
    .last (cnt_last)
  );

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LD_M;
      S_LD_M:  state_nxt = S_LD_Q;
      S_LD_Q:  state_nxt = S_DEC;
      // q0/q_lsb have already settled from the LD_Q or SHF edge here.
      S_DEC: begin
        case ({q0, q_lsb})
          BOOTH_ADD: state_nxt = S_ADD;
          BOOTH_SUB: state_nxt = S_SUB;
          default:   state_nxt = S_SHF;
        endcase
      end
      S_ADD:   state_nxt = S_SHF;
      S_SUB:   state_nxt = S_SHF;
      S_SHF:   state_nxt = cnt_last ? S_OUT_A : S_DEC;
      S_OUT_A: state_nxt = S_OUT_Q;
      S_OUT_Q: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      ctrl_q <= ctrl_decode(S_IDLE);
    end else begin
      state  <= state_nxt;
      ctrl_q <= ctrl_decode(state_nxt);
    end
  end

  assign {c7, c6, c5, c4, c3, c2, c1, c0} = ctrl_q.c;
  assign ready = ctrl_q.ready;
  assign done  = ctrl_q.done;

endmodule
